// File: rtl/washing_machine_ctrl.sv
// -----------------------------------------------------------------------------
// washing_machine_ctrl
//
// Cycle controller for a washing machine. After a start request it waits in
// READY for a programme (mode), then runs SOAK, WASH, one or more RINSE passes
// and SPIN. Each phase is timed by a down-counter loaded with its duration.
//
// Optional feature macro: WM_PAUSE_EN
//   defined   : opening the lid during a phase pauses the cycle (PAUSE state).
//               Closing it resumes the same phase with the counter unchanged.
//   undefined : opening the lid during a phase aborts to IDLE with a fault pulse.
//
// Parameters
//   CNT_W  width of phase durations and of the phase counter
//   REP_W  width of the rinse repeat count and of the rinse index
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       start request (level, sampled every cycle)
//   cancel      abort request (highest priority)
//   lid         0 = closed, 1 = open
//   mode        00 none, 01 quick, 10 normal, 11 heavy
//   soak_time, wash_time, rinse_time, spin_time  phase durations in cycles
//   rinse_reps  number of rinse passes (0 behaves as 1)
//   state       IDLE=0 READY=1 SOAK=2 WASH=3 RINSE=4 SPIN=5 PAUSE=6
//               (this is the FSM state register itself, usable by checkers)
//   soak_en, wash_en, rinse_en, spin_en  phase enables
//   busy        high whenever state != IDLE
//   done        one-cycle pulse in the first IDLE cycle after SPIN ends
//   fault       one-cycle pulse after a lid abort
//   remaining   current phase counter value
//   rinse_idx   zero-based index of the current rinse pass
//
// Handshake: the block has no valid/ready pairs. start, cancel, lid and mode
// are level inputs sampled on every rising edge; done and fault are
// single-cycle pulses that are not held and need no acknowledge.
// -----------------------------------------------------------------------------
module washing_machine_ctrl #(
  parameter int CNT_W = 16,
  parameter int REP_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic             lid,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] soak_time,
  input  logic [CNT_W-1:0] wash_time,
  input  logic [CNT_W-1:0] rinse_time,
  input  logic [CNT_W-1:0] spin_time,
  input  logic [REP_W-1:0] rinse_reps,
  output logic [2:0]       state,
  output logic             soak_en,
  output logic             wash_en,
  output logic             rinse_en,
  output logic             spin_en,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] remaining,
  output logic [REP_W-1:0] rinse_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_SOAK  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_PAUSE = 3'd6
  } state_t;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_QUICK = 2'b01;
  localparam logic [1:0] MODE_HEAVY = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] soak_q, soak_d;
  logic [CNT_W-1:0] wash_q, wash_d;
  logic [CNT_W-1:0] rinse_q, rinse_d;
  logic [CNT_W-1:0] spin_q, spin_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             done_d, fault_d;

`ifdef WM_PAUSE_EN
  // Phase that was interrupted by an open lid; restored on resume.
  state_t           saved_q, saved_d;
`endif

  // Heavy mode doubles the wash time; the extra top bit catches overflow so
  // the duration saturates at all-ones instead of wrapping.
  logic [CNT_W:0]   wash_x2;
  logic [CNT_W-1:0] wash_heavy;
  logic [CNT_W-1:0] wash_dur;
  logic [REP_W-1:0] last_pass;

  assign wash_x2    = {wash_q, 1'b0};
  assign wash_heavy = wash_x2[CNT_W] ? {CNT_W{1'b1}} : wash_x2[CNT_W-1:0];
  assign wash_dur   = (mode_q == MODE_HEAVY) ? wash_heavy : wash_q;

  // A repeat count of 0 still runs one rinse pass.
  assign last_pass  = (reps_q == '0) ? '0 : reps_q - REP_W'(1);

  // The counter holds D-1 on entry so the phase lasts D cycles; a zero
  // duration loads 0 and therefore lasts a single cycle.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    soak_d    = soak_q;
    wash_d    = wash_q;
    rinse_d   = rinse_q;
    spin_d    = spin_q;
    reps_d    = reps_q;
    done_d    = 1'b0;
    fault_d   = 1'b0;
`ifdef WM_PAUSE_EN
    saved_d   = saved_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cancel) begin
          pending_d = 1'b0;
        end else if ((start || pending_q) && !lid) begin
          state_d   = S_READY;
          pending_d = 1'b0;
          cnt_d     = '0;
          idx_d     = '0;
          soak_d    = soak_time;
          wash_d    = wash_time;
          rinse_d   = rinse_time;
          spin_d    = spin_time;
          reps_d    = rinse_reps;
        end else if (start) begin
          // Lid is open: remember the request until it closes.
          pending_d = 1'b1;
        end
      end

      S_READY: begin
        if (cancel) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          idx_d     = '0;
          pending_d = 1'b0;
        end else if ((mode != MODE_NONE) && !lid) begin
          mode_d = mode;
          if (mode == MODE_QUICK) begin
            // Quick programme has no soak and never doubles the wash time.
            state_d = S_WASH;
            cnt_d   = load_val(wash_q);
          end else begin
            state_d = S_SOAK;
            cnt_d   = load_val(soak_q);
          end
        end
      end

      S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
        if (cancel) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          idx_d     = '0;
          pending_d = 1'b0;
        end else if (lid) begin
`ifdef WM_PAUSE_EN
          // Freeze: counter and rinse index keep their values.
          state_d = S_PAUSE;
          saved_d = state_q;
`else
          state_d   = S_IDLE;
          cnt_d     = '0;
          idx_d     = '0;
          pending_d = 1'b0;
          fault_d   = 1'b1;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Counter reached zero: this edge ends the phase.
          case (state_q)
            S_SOAK: begin
              state_d = S_WASH;
              cnt_d   = load_val(wash_dur);
            end
            S_WASH: begin
              state_d = S_RINSE;
              idx_d   = '0;
              cnt_d   = load_val(rinse_q);
            end
            S_RINSE: begin
              if (idx_q == last_pass) begin
                state_d = S_SPIN;
                idx_d   = '0;
                cnt_d   = load_val(spin_q);
              end else begin
                idx_d = idx_q + REP_W'(1);
                cnt_d = load_val(rinse_q);
              end
            end
            default: begin
              // End of SPIN: cycle complete.
              state_d = S_IDLE;
              cnt_d   = '0;
              idx_d   = '0;
              done_d  = 1'b1;
            end
          endcase
        end
      end

`ifdef WM_PAUSE_EN
      S_PAUSE: begin
        if (cancel) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          idx_d     = '0;
          pending_d = 1'b0;
        end else if (!lid) begin
          state_d = saved_q;
        end
      end
`endif

      default: begin
        // Unreachable encodings (including PAUSE without the pause feature).
        state_d   = S_IDLE;
        cnt_d     = '0;
        idx_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Enables and busy are registered from the
  // next state so they line up exactly with the state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      mode_q    <= MODE_NONE;
      soak_q    <= '0;
      wash_q    <= '0;
      rinse_q   <= '0;
      spin_q    <= '0;
      reps_q    <= '0;
      soak_en   <= 1'b0;
      wash_en   <= 1'b0;
      rinse_en  <= 1'b0;
      spin_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      soak_q    <= soak_d;
      wash_q    <= wash_d;
      rinse_q   <= rinse_d;
      spin_q    <= spin_d;
      reps_q    <= reps_d;
      soak_en   <= (state_d == S_SOAK);
      wash_en   <= (state_d == S_WASH);
      rinse_en  <= (state_d == S_RINSE);
      spin_en   <= (state_d == S_SPIN);
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      fault     <= fault_d;
    end
  end

`ifdef WM_PAUSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saved_q <= S_IDLE;
    end else begin
      saved_q <= saved_d;
    end
  end
`endif

  assign state     = state_q;
  assign remaining = cnt_q;
  assign rinse_idx = idx_q;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// -----------------------------------------------------------------------------
// tb_washing_machine_ctrl
//
// Main DUT (CNT_W=16, REP_W=2) is checked through an event scoreboard: the
// stimulus pushes the hand-computed record of every expected output event
// (state change, rinse index change, done or fault pulse) and a monitor pops
// and compares each event it sees. A record also carries the number of cycles
// the previous state lasted (dwell); dwell 0 in an expected record means
// "not checked". A second DUT with CNT_W=4 covers heavy-mode saturation.
// -----------------------------------------------------------------------------
module tb_washing_machine_ctrl;

  localparam int W = 36;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READY = 3'd1;
  localparam logic [2:0] ST_SOAK  = 3'd2;
  localparam logic [2:0] ST_WASH  = 3'd3;
  localparam logic [2:0] ST_RINSE = 3'd4;
  localparam logic [2:0] ST_SPIN  = 3'd5;
`ifdef WM_PAUSE_EN
  localparam logic [2:0] ST_PAUSE = 3'd6;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        start, cancel, lid;
  logic [1:0]  mode;
  logic [15:0] soak_time, wash_time, rinse_time, spin_time;
  logic [1:0]  rinse_reps;
  logic [2:0]  state;
  logic        soak_en, wash_en, rinse_en, spin_en, busy, done, fault;
  logic [15:0] remaining;
  logic [1:0]  rinse_idx;

  washing_machine_ctrl #(.CNT_W(16), .REP_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .lid(lid),
    .mode(mode), .soak_time(soak_time), .wash_time(wash_time),
    .rinse_time(rinse_time), .spin_time(spin_time), .rinse_reps(rinse_reps),
    .state(state), .soak_en(soak_en), .wash_en(wash_en), .rinse_en(rinse_en),
    .spin_en(spin_en), .busy(busy), .done(done), .fault(fault),
    .remaining(remaining), .rinse_idx(rinse_idx)
  );

  // ---------------- small DUT ----------------
  logic        s_start, s_cancel, s_lid;
  logic [1:0]  s_mode;
  logic [3:0]  s_soak, s_wash, s_rinse, s_spin;
  logic [1:0]  s_reps;
  logic [2:0]  s_state;
  logic        s_soak_en, s_wash_en, s_rinse_en, s_spin_en, s_busy, s_done, s_fault;
  logic [3:0]  s_remaining;
  logic [1:0]  s_rinse_idx;

  washing_machine_ctrl #(.CNT_W(4), .REP_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .cancel(s_cancel), .lid(s_lid),
    .mode(s_mode), .soak_time(s_soak), .wash_time(s_wash),
    .rinse_time(s_rinse), .spin_time(s_spin), .rinse_reps(s_reps),
    .state(s_state), .soak_en(s_soak_en), .wash_en(s_wash_en),
    .rinse_en(s_rinse_en), .spin_en(s_spin_en), .busy(s_busy), .done(s_done),
    .fault(s_fault), .remaining(s_remaining), .rinse_idx(s_rinse_idx)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [W-1:0] rec(input logic [2:0] st, input logic [15:0] rem,
                                       input logic [1:0] idx, input logic dn,
                                       input logic ft, input logic [3:0] en,
                                       input logic bz, input logic [7:0] dw);
    return {st, rem, idx, dn, ft, en, bz, dw};
  endfunction

  task automatic expect_ev(input logic [2:0] st, input logic [15:0] rem,
                           input logic [1:0] idx, input logic dn, input logic ft,
                           input logic [3:0] en, input logic bz, input logic [7:0] dw);
    exp_q.push_back(rec(st, rem, idx, dn, ft, en, bz, dw));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic monitor_loop();
    logic [2:0]   prev_st;
    logic [1:0]   prev_idx;
    int           cnt;
    logic [W-1:0] act;
    logic [W-1:0] req;
    logic         ev;
    prev_st  = ST_IDLE;
    prev_idx = 2'd0;
    cnt      = 0;
    forever begin
      @(negedge clk);
      ev = (state != prev_st) || done || fault || (rinse_idx != prev_idx);
      if (ev) begin
        act = rec(state, remaining, rinse_idx, done, fault,
                  {soak_en, wash_en, rinse_en, spin_en}, busy,
                  (cnt + 1 > 255) ? 8'd255 : 8'(cnt + 1));
        cnt = 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event actual=%h (state=%0d rem=%0d) required=none",
                   act, state, remaining);
        end else begin
          req = exp_q.pop_front();
          if (req[7:0] == 8'd0) act[7:0] = 8'd0;
          if (act !== req) begin
            n_fail++;
            $display("FAIL event actual st=%0d rem=%0d idx=%0d done=%0b fault=%0b en=%b busy=%0b dwell=%0d required st=%0d rem=%0d idx=%0d done=%0b fault=%0b en=%b busy=%0b dwell=%0d",
                     act[35:33], act[32:17], act[16:15], act[14], act[13], act[12:9], act[8], act[7:0],
                     req[35:33], req[32:17], req[16:15], req[14], req[13], req[12:9], req[8], req[7:0]);
          end
        end
      end else begin
        cnt++;
      end
      prev_st  = state;
      prev_idx = rinse_idx;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic set_dur(input logic [15:0] sk, input logic [15:0] wa,
                         input logic [15:0] ri, input logic [15:0] sp,
                         input logic [1:0] rp, input logic [1:0] md);
    soak_time = sk; wash_time = wa; rinse_time = ri; spin_time = sp;
    rinse_reps = rp; mode = md;
  endtask

  task automatic wait_for(input string name, input logic [2:0] st,
                          input logic [15:0] rem, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (state == st && remaining == rem) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_reached"}, {63'd0, found}, 64'd1);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      step(1);
      guard++;
    end
    check({name, "_events_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    step(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 0; cancel = 0; lid = 0; mode = 0;
    soak_time = 0; wash_time = 0; rinse_time = 0; spin_time = 0; rinse_reps = 0;
    s_start = 0; s_cancel = 0; s_lid = 0; s_mode = 0;
    s_soak = 0; s_wash = 0; s_rinse = 0; s_spin = 0; s_reps = 0;
    fork
      monitor_loop();
    join_none

    #1;
    check("reset_outputs",
          64'({state, soak_en, wash_en, rinse_en, spin_en, busy, done, fault, remaining, rinse_idx}),
          64'd0);
    step(2);
    rst = 1'b0;
    step(2);

    // Normal run 3/4/2/5, two rinse passes
    set_dur(16'd3, 16'd4, 16'd2, 16'd5, 2'd2, 2'b10);
    expect_ev(ST_READY, 16'd0, 2'd0, 0, 0, 4'b0000, 1, 8'd0);
    expect_ev(ST_SOAK,  16'd2, 2'd0, 0, 0, 4'b1000, 1, 8'd1);
    expect_ev(ST_WASH,  16'd3, 2'd0, 0, 0, 4'b0100, 1, 8'd3);
    expect_ev(ST_RINSE, 16'd1, 2'd0, 0, 0, 4'b0010, 1, 8'd4);
    expect_ev(ST_RINSE, 16'd1, 2'd1, 0, 0, 4'b0010, 1, 8'd2);
    expect_ev(ST_SPIN,  16'd4, 2'd0, 0, 0, 4'b0001, 1, 8'd2);
    expect_ev(ST_IDLE,  16'd0, 2'd0, 1, 0, 4'b0000, 0, 8'd5);
    pulse_start();
    drain("normal");
    mode = 2'b00;

    // Quick run, zero spin time, zero repeat count
    set_dur(16'd3, 16'd2, 16'd1, 16'd0, 2'd0, 2'b01);
    expect_ev(ST_READY, 16'd0, 2'd0, 0, 0, 4'b0000, 1, 8'd0);
    expect_ev(ST_WASH,  16'd1, 2'd0, 0, 0, 4'b0100, 1, 8'd1);
    expect_ev(ST_RINSE, 16'd0, 2'd0, 0, 0, 4'b0010, 1, 8'd2);
    expect_ev(ST_SPIN,  16'd0, 2'd0, 0, 0, 4'b0001, 1, 8'd1);
    expect_ev(ST_IDLE,  16'd0, 2'd0, 1, 0, 4'b0000, 0, 8'd1);
    pulse_start();
    drain("quick");
    mode = 2'b00;

    // Heavy run (wash 5 -> 10 cycles), cancel+start together at remaining=2
    set_dur(16'd1, 16'd5, 16'd1, 16'd1, 2'd1, 2'b11);
    expect_ev(ST_READY, 16'd0, 2'd0, 0, 0, 4'b0000, 1, 8'd0);
    expect_ev(ST_SOAK,  16'd0, 2'd0, 0, 0, 4'b1000, 1, 8'd1);
    expect_ev(ST_WASH,  16'd9, 2'd0, 0, 0, 4'b0100, 1, 8'd1);
    expect_ev(ST_IDLE,  16'd0, 2'd0, 0, 0, 4'b0000, 0, 8'd8);
    pulse_start();
    wait_for("cancel_wash", ST_WASH, 16'd2, 40);
    cancel = 1'b1; start = 1'b1;
    step(1);
    cancel = 1'b0; start = 1'b0;
    drain("cancel");
    check("cancel_stays_idle", 64'(state), 64'(ST_IDLE));
    mode = 2'b00;

    // Lid opened for 3 cycles in RINSE at remaining=1
    set_dur(16'd1, 16'd1, 16'd3, 16'd2, 2'd1, 2'b10);
    expect_ev(ST_READY, 16'd0, 2'd0, 0, 0, 4'b0000, 1, 8'd0);
    expect_ev(ST_SOAK,  16'd0, 2'd0, 0, 0, 4'b1000, 1, 8'd1);
    expect_ev(ST_WASH,  16'd0, 2'd0, 0, 0, 4'b0100, 1, 8'd1);
    expect_ev(ST_RINSE, 16'd2, 2'd0, 0, 0, 4'b0010, 1, 8'd1);
`ifdef WM_PAUSE_EN
    expect_ev(ST_PAUSE, 16'd1, 2'd0, 0, 0, 4'b0000, 1, 8'd2);
    expect_ev(ST_RINSE, 16'd1, 2'd0, 0, 0, 4'b0010, 1, 8'd3);
    expect_ev(ST_SPIN,  16'd1, 2'd0, 0, 0, 4'b0001, 1, 8'd2);
    expect_ev(ST_IDLE,  16'd0, 2'd0, 1, 0, 4'b0000, 0, 8'd2);
`else
    expect_ev(ST_IDLE,  16'd0, 2'd0, 0, 1, 4'b0000, 0, 8'd2);
`endif
    pulse_start();
    wait_for("lid_rinse", ST_RINSE, 16'd1, 30);
    lid = 1'b1;
    step(3);
    lid = 1'b0;
    drain("lid");
    mode = 2'b00;

    // Cancel in IDLE drops a pending start
    lid = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0; cancel = 1'b1;
    step(1);
    cancel = 1'b0; lid = 1'b0;
    step(2);
    check("pending_cleared_by_cancel", 64'(state), 64'(ST_IDLE));

    // Start with lid open, lid closes two cycles later, then reset mid-SPIN
    set_dur(16'd1, 16'd1, 16'd1, 16'd6, 2'd1, 2'b10);
    expect_ev(ST_READY, 16'd0, 2'd0, 0, 0, 4'b0000, 1, 8'd0);
    expect_ev(ST_SOAK,  16'd0, 2'd0, 0, 0, 4'b1000, 1, 8'd1);
    expect_ev(ST_WASH,  16'd0, 2'd0, 0, 0, 4'b0100, 1, 8'd1);
    expect_ev(ST_RINSE, 16'd0, 2'd0, 0, 0, 4'b0010, 1, 8'd1);
    expect_ev(ST_SPIN,  16'd5, 2'd0, 0, 0, 4'b0001, 1, 8'd1);
    expect_ev(ST_IDLE,  16'd0, 2'd0, 0, 0, 4'b0000, 0, 8'd0);
    lid = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("pending_held_while_lid_open", 64'(state), 64'(ST_IDLE));
    lid = 1'b0;
    step(1);
    check("ready_after_lid_closes", 64'(state), 64'(ST_READY));
    wait_for("spin_mid", ST_SPIN, 16'd3, 30);
    #1 rst = 1'b1;
    #1;
    check("reset_mid_spin",
          64'({state, soak_en, wash_en, rinse_en, spin_en, busy, done, fault, remaining, rinse_idx}),
          64'd0);
    step(1);
    rst = 1'b0;
    mode = 2'b00;
    drain("reset");
    step(3);
    check("new_start_required", 64'({state, busy}), 64'd0);

    // Heavy saturation on the 4-bit DUT: 9*2 saturates to 15
    begin
      int wash_cycles;
      int done_pulses;
      logic [3:0] first_rem;
      logic seen;
      wash_cycles = 0; done_pulses = 0; first_rem = 4'd0; seen = 1'b0;
      s_soak = 4'd1; s_wash = 4'd9; s_rinse = 4'd1; s_spin = 4'd1;
      s_reps = 2'd1; s_mode = 2'b11;
      s_start = 1'b1;
      step(1);
      s_start = 1'b0;
      repeat (60) begin
        @(negedge clk);
        if (s_wash_en) begin
          if (!seen) first_rem = s_remaining;
          seen = 1'b1;
          wash_cycles++;
        end
        if (s_done) done_pulses++;
      end
      check("heavy_sat_wash_cycles", 64'(wash_cycles), 64'd15);
      check("heavy_sat_first_remaining", 64'(first_rem), 64'd14);
      check("heavy_sat_done_pulses", 64'(done_pulses), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
